// File: rtl/game_round_controller.sv
// Game flow FSM (title/select/play/round-end/game-over) with per-player lives, invulnerability and round wins.
// Every output is registered and changes one Clk after its cause; there is no backpressure, and inputs are sampled every cycle.
module game_round_controller #(
    parameter int N_PLAYERS        = 2,
    parameter int START_LIVES      = 3,
    parameter int INVULN_FRAMES    = 60,
    parameter int ROUND_END_FRAMES = 120,
    parameter int WINS_TO_MATCH    = 3
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   frame_tick,
    input  logic                   next_btn,
    input  logic [N_PLAYERS-1:0]   hit,
    output logic [2:0]             state,
    output logic                   freeze,
    output logic                   respawn,
    output logic [N_PLAYERS-1:0]   alive,
    output logic [4*N_PLAYERS-1:0] lives,
    output logic [4*N_PLAYERS-1:0] wins,
    output logic [7:0]             round_count,
    output logic [2:0]             winner,
    output logic                   winner_valid
);
    localparam int INV_W = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam int RE_W  = (ROUND_END_FRAMES < 2) ? 1 : $clog2(ROUND_END_FRAMES + 1);

    localparam logic [3:0]       START_L  = 4'(START_LIVES);
    localparam logic [3:0]       WINS_L   = 4'(WINS_TO_MATCH);
    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);
    localparam logic [RE_W-1:0]  RE_LAST  = RE_W'(ROUND_END_FRAMES - 1);

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_SELECT    = 3'd1,
        ST_PLAY      = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   freeze_q, freeze_d;
    logic                   respawn_q, respawn_d;
    logic [N_PLAYERS-1:0]   alive_q, alive_d;
    logic [4*N_PLAYERS-1:0] lives_q, lives_d;
    logic [4*N_PLAYERS-1:0] wins_q, wins_d;
    logic [7:0]             round_q, round_d;
    logic [2:0]             winner_q, winner_d;
    logic                   winner_vld_q, winner_vld_d;
    logic [INV_W-1:0]       inv_q [N_PLAYERS];
    logic [INV_W-1:0]       inv_d [N_PLAYERS];
    logic [RE_W-1:0]        re_cnt_q, re_cnt_d;
    logic                   next_btn_q;

    logic                   next_edge;
    logic                   start_round;
    logic                   any_match;
    logic [3:0]             alive_cnt;
    logic [2:0]             last_alive;

    always_comb begin
        next_edge    = next_btn & ~next_btn_q;
        state_d      = state_q;
        respawn_d    = 1'b0;
        alive_d      = alive_q;
        lives_d      = lives_q;
        wins_d       = wins_q;
        round_d      = round_q;
        winner_d     = winner_q;
        winner_vld_d = winner_vld_q;
        re_cnt_d     = re_cnt_q;
        start_round  = 1'b0;
        any_match    = 1'b0;
        alive_cnt    = 4'd0;
        last_alive   = 3'd0;

        for (int i = 0; i < N_PLAYERS; i++) begin
            inv_d[i] = inv_q[i];
            if (frame_tick && (inv_q[i] != '0)) begin
                inv_d[i] = inv_q[i] - INV_W'(1);
            end
            if (wins_q[4*i +: 4] >= WINS_L) begin
                any_match = 1'b1;
            end
        end

        case (state_q)
            ST_TITLE: begin
                if (next_edge) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (next_edge) begin
                    start_round = 1'b1;
                    wins_d      = '0;
                    round_d     = 8'd1;
                end
            end
            ST_PLAY: begin
                // A hit load overrides the frame-tick decrement computed above.
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (hit[i] && alive_q[i] && (inv_q[i] == '0)) begin
                        lives_d[4*i +: 4] = lives_q[4*i +: 4] - 4'd1;
                        inv_d[i]          = INV_LOAD;
                        if (lives_q[4*i +: 4] == 4'd1) begin
                            alive_d[i] = 1'b0;
                        end
                    end
                end
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (alive_d[i]) begin
                        alive_cnt  = alive_cnt + 4'd1;
                        last_alive = 3'(i);
                    end
                end
                if (alive_cnt <= 4'd1) begin
                    state_d      = ST_ROUND_END;
                    re_cnt_d     = '0;
                    winner_vld_d = (alive_cnt == 4'd1);
                    if (alive_cnt == 4'd1) begin
                        winner_d = last_alive;
                    end
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if ((alive_cnt == 4'd1) && alive_d[i] && (wins_q[4*i +: 4] != 4'hf)) begin
                            wins_d[4*i +: 4] = wins_q[4*i +: 4] + 4'd1;
                        end
                    end
                end
            end
            ST_ROUND_END: begin
                if (frame_tick) begin
                    if (re_cnt_q == RE_LAST) begin
                        if (any_match) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            start_round = 1'b1;
                            if (round_q != 8'hff) begin
                                round_d = round_q + 8'd1;
                            end
                        end
                    end else begin
                        re_cnt_d = re_cnt_q + RE_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (next_edge) begin
                    state_d      = ST_TITLE;
                    wins_d       = '0;
                    winner_vld_d = 1'b0;
                    round_d      = 8'd0;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase

        // Shared by the first round after SELECT and every later round.
        if (start_round) begin
            state_d      = ST_PLAY;
            respawn_d    = 1'b1;
            lives_d      = {N_PLAYERS{START_L}};
            alive_d      = '1;
            winner_vld_d = 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                inv_d[i] = '0;
            end
        end

        freeze_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_TITLE;
            freeze_q     <= 1'b1;
            respawn_q    <= 1'b0;
            alive_q      <= '1;
            lives_q      <= {N_PLAYERS{START_L}};
            wins_q       <= '0;
            round_q      <= 8'd0;
            winner_q     <= 3'd0;
            winner_vld_q <= 1'b0;
            re_cnt_q     <= '0;
            next_btn_q   <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                inv_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            freeze_q     <= freeze_d;
            respawn_q    <= respawn_d;
            alive_q      <= alive_d;
            lives_q      <= lives_d;
            wins_q       <= wins_d;
            round_q      <= round_d;
            winner_q     <= winner_d;
            winner_vld_q <= winner_vld_d;
            re_cnt_q     <= re_cnt_d;
            next_btn_q   <= next_btn;
            for (int i = 0; i < N_PLAYERS; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    assign state        = state_q;
    assign freeze       = freeze_q;
    assign respawn      = respawn_q;
    assign alive        = alive_q;
    assign lives        = lives_q;
    assign wins         = wins_q;
    assign round_count  = round_q;
    assign winner       = winner_q;
    assign winner_valid = winner_vld_q;

endmodule
